// File: rtl/accum_cmd_driver_pkg.sv
// Shared constants and helpers for the accumulator command driver.
// Command words are packed {A, B, Sel, AddSub} from MSB to LSB.
package accum_cmd_driver_pkg;

    localparam int CMD_ADDSUB = 0;
    localparam int CMD_SEL    = 1;
    localparam int CMD_B_LSB  = 2;

    function automatic int cmd_a_lsb(input int w);
        return CMD_B_LSB + w;
    endfunction

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/accum_cmd_driver_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data reads as zero when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module accum_cmd_driver_sync_fifo
    import accum_cmd_driver_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = log2c(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_q[AW-1] != rd_q[AW-1]) &&
                     (wr_q[AW-2:0] == rd_q[AW-2:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-2:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-2:0]];

endmodule

// File: rtl/accum_cmd_driver.sv
// Command-side initiator for the add/subtract accumulator unit: buffers commands,
// issues one per cycle under result-FIFO credit, and returns Z/Overflow in order.
module accum_cmd_driver
    import accum_cmd_driver_pkg::*;
#(
    parameter int n      = 16,
    parameter int LAT    = 2,
    parameter int CDEPTH = 4,
    parameter int RDEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic         cmd_sel,
    input  logic         cmd_addsub,
    output logic [n-1:0] A,
    output logic [n-1:0] B,
    output logic         Sel,
    output logic         AddSub,
    input  logic [n-1:0] Z,
    input  logic         Overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_z,
    output logic         res_ovf,
    output logic         busy
);

    localparam int CW   = 2 * n + 2;
    localparam int RW   = n + 1;
    localparam int ALSB = cmd_a_lsb(n);
    localparam int CRW  = log2c(RDEPTH) + 1;

    logic [CW-1:0]  c_head;
    logic           c_full;
    logic           c_empty;
    logic           c_push;
    logic [RW-1:0]  r_head;
    logic           r_full;
    logic           r_empty;
    logic           r_pop;

    logic           issue;
    logic           capture;

    logic [n-1:0]   a_q, a_d;
    logic [n-1:0]   b_q, b_d;
    logic           sel_q, sel_d;
    logic           addsub_q, addsub_d;
    logic           tag_q, tag_d;
    logic [LAT-1:0] pipe_q, pipe_d;
    logic [CRW-1:0] credit_q, credit_d;

    assign cmd_ready = Reset & ~c_full;
    assign c_push    = cmd_valid & cmd_ready;

    accum_cmd_driver_sync_fifo #(
        .W     (CW),
        .DEPTH (CDEPTH)
    ) u_cmd_fifo (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .push_i  (c_push),
        .wdata_i ({cmd_a, cmd_b, cmd_sel, cmd_addsub}),
        .pop_i   (issue),
        .rdata_o (c_head),
        .full_o  (c_full),
        .empty_o (c_empty)
    );

    assign issue   = ~c_empty && (credit_q != '0);
    // tag_q travels with the issue register; Z matches LAT stages later
    assign capture = pipe_q[LAT-1];

    always_comb begin
        a_d      = '0;
        b_d      = '0;
        sel_d    = 1'b1;
        addsub_d = 1'b0;
        tag_d    = 1'b0;
        if (issue) begin
            a_d      = c_head[ALSB +: n];
            b_d      = c_head[CMD_B_LSB +: n];
            sel_d    = c_head[CMD_SEL];
            addsub_d = c_head[CMD_ADDSUB];
            tag_d    = 1'b1;
        end
        pipe_d[0] = tag_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        credit_d = credit_q;
        unique case ({issue, r_pop})
            2'b10:   credit_d = credit_q - CRW'(1);
            2'b01:   credit_d = credit_q + CRW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b1;
            addsub_q <= 1'b0;
            tag_q    <= 1'b0;
            pipe_q   <= '0;
            credit_q <= CRW'(RDEPTH);
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            addsub_q <= addsub_d;
            tag_q    <= tag_d;
            pipe_q   <= pipe_d;
            credit_q <= credit_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign Sel    = sel_q;
    assign AddSub = addsub_q;

    accum_cmd_driver_sync_fifo #(
        .W     (RW),
        .DEPTH (RDEPTH)
    ) u_res_fifo (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .push_i  (capture),
        .wdata_i ({Z, Overflow}),
        .pop_i   (r_pop),
        .rdata_o (r_head),
        .full_o  (r_full),
        .empty_o (r_empty)
    );

    assign res_valid = ~r_empty;
    assign r_pop     = res_valid & res_ready;
    assign res_z     = r_head[RW-1:1];
    assign res_ovf   = r_head[0];

    assign busy = ~c_empty | tag_q | (|pipe_q) | ~r_empty;

    logic unused_full;
    assign unused_full = r_full;

endmodule

// File: tb/tb_accum_cmd_driver.sv
// Randomized bench for accum_cmd_driver with a behavioural accumulator unit
// and an in-order reference queue of expected results.
module tb_accum_cmd_driver;

    logic        Clock;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_sel;
    logic        cmd_addsub;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sel;
    logic        AddSub;
    logic [15:0] Z;
    logic        Overflow;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_z;
    logic        res_ovf;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    int n_acc = 0;
    int n_pop = 0;
    int rr_mode = 0;
    int ref_acc = 0;
    logic [16:0] exp_q[$];

    accum_cmd_driver dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_addsub (cmd_addsub),
        .A          (A),
        .B          (B),
        .Sel        (Sel),
        .AddSub     (AddSub),
        .Z          (Z),
        .Overflow   (Overflow),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_z      (res_z),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural accumulator unit: two registered stages, signed overflow
    logic [15:0] u_acc = '0;
    logic        u_aov = 1'b0;
    logic [15:0] u_z   = '0;
    logic        u_ov  = 1'b0;

    function automatic logic [16:0] unit_op(input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic sub);
        logic [15:0] s;
        logic v;
        s = sub ? x - y : x + y;
        if (sub) v = (x[15] != y[15]) && (s[15] != x[15]);
        else     v = (x[15] == y[15]) && (s[15] != x[15]);
        return {v, s};
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            {u_aov, u_acc} <= unit_op(Sel ? u_acc : A, B, AddSub);
        end
        u_z  <= u_acc;
        u_ov <= u_aov;
    end

    assign Z        = u_z;
    assign Overflow = u_ov;

    always begin
        @(posedge Clock);
        #2;
        if (rr_mode == 2) res_ready = ($urandom % 4) != 0;
        else              res_ready = (rr_mode == 1);
    end

    // Reference: commands applied strictly in acceptance order
    always @(negedge Clock) begin
        int x, r;
        logic [15:0] rs;
        logic [16:0] e;
        if (!Reset) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("spurious_res", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_z", 32'(res_z), 32'(e[15:0]));
                    chk("res_ovf", 32'(res_ovf), 32'(e[16]));
                end
            end
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                x  = cmd_sel ? ref_acc : int'($signed(cmd_a));
                r  = cmd_addsub ? x - int'($signed(cmd_b))
                                : x + int'($signed(cmd_b));
                rs = r[15:0];
                exp_q.push_back({(r > 32767 || r < -32768), rs});
                ref_acc = int'($signed(rs));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ad);
        int g;
        cmd_a      = a;
        cmd_b      = b;
        cmd_sel    = s;
        cmd_addsub = ad;
        cmd_valid  = 1'b1;
        g = 0;
        @(negedge Clock);
        while (!cmd_ready && g < 300) begin
            @(negedge Clock);
            g++;
        end
        if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
        @(posedge Clock);
        #1;
    endtask

    task automatic send_rand(input logic s);
        send(16'($urandom), 16'($urandom), s, 1'($urandom));
    endtask

    task automatic idle(input int cycles);
        cmd_valid = 1'b0;
        repeat (cycles) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic wait_rv(input string tag, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
        chk(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int g;
        cmd_valid = 1'b0;
        rr_mode = 1;
        g = 0;
        @(negedge Clock);
        while ((exp_q.size() != 0 || busy) && g < 200) begin
            @(negedge Clock);
            g++;
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int cyc, a0, p0;
        Reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_sel    = 1'b0;
        cmd_addsub = 1'b0;
        res_ready  = 1'b0;

        repeat (3) begin
            @(negedge Clock);
            chk("rst_ready", 32'(cmd_ready), 32'd0);
            chk("rst_A", 32'(A), 32'd0);
            chk("rst_B", 32'(B), 32'd0);
            chk("rst_Sel", 32'(Sel), 32'd1);
            chk("rst_AddSub", 32'(AddSub), 32'd0);
            chk("rst_rv", 32'(res_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge Clock);
        #1;

        rr_mode = 1;
        idle(1);
        p0 = n_pop;
        send(16'd54, 16'd1850, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_rv("single_rv", cyc);
        chk("single_latency", 32'(cyc), 32'd4);
        chk("single_z", 32'(res_z), 32'd1904);
        idle(8);
        chk("single_pops", 32'(n_pop - p0), 32'd1);

        send(16'd750, 16'd120, 1'b0, 1'b1);
        send(16'd0, 16'd7000, 1'b1, 1'b0);
        send(16'd0, 16'd30000, 1'b1, 1'b0);
        send(16'd0, 16'd5, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        wait_rv("burst_rv0", cyc);
        repeat (4) begin
            @(negedge Clock);
            chk("burst_rv", 32'(res_valid), 32'd1);
        end
        drain("burst");

        rr_mode = 0;
        idle(2);
        a0 = n_acc;
        p0 = n_pop;
        send_rand(1'b0);
        repeat (7) send_rand(1'($urandom));
        cmd_valid = 1'b0;
        @(negedge Clock);
        chk("bp_full", 32'(cmd_ready), 32'd0);
        cmd_a = 16'($urandom);
        cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge Clock);
            chk("bp_blocked", 32'(cmd_ready), 32'd0);
            chk("bp_rv", 32'(res_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        chk("bp_acc8", 32'(n_acc - a0), 32'd8);
        @(posedge Clock);
        #1;
        drain("bp");
        chk("bp_pop8", 32'(n_pop - p0), 32'd8);

        rr_mode = 0;
        idle(2);
        send(16'd100, 16'd23, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        wait_rv("rm_rv", cyc);
        send_rand(1'b1);
        send_rand(1'b1);
        cmd_valid = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (6) begin
            @(negedge Clock);
            chk("rm_no_rv", 32'(res_valid), 32'd0);
            chk("rm_busy", 32'(busy), 32'd0);
        end
        @(posedge Clock);
        #1;
        rr_mode = 1;
        send(16'd1000, 16'd1, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        drain("rm");

        rr_mode = 0;
        idle(2);
        send_rand(1'b0);
        repeat (6) send_rand(1'($urandom));
        cmd_valid = 1'b0;
        @(negedge Clock);
        chk("d3_ready", 32'(cmd_ready), 32'd1);
        @(posedge Clock);
        #1;
        rr_mode = 1;
        @(posedge Clock);
        #1;
        rr_mode = 0;
        cmd_a = 16'($urandom);
        cmd_b = 16'($urandom);
        cmd_sel = 1'b1;
        cmd_addsub = 1'($urandom);
        cmd_valid = 1'b1;
        @(posedge Clock);
        #1;
        cmd_b = 16'($urandom);
        @(negedge Clock);
        chk("simul_ready", 32'(cmd_ready), 32'd1);
        @(posedge Clock);
        #1;
        cmd_valid = 1'b0;
        @(negedge Clock);
        chk("simul_full", 32'(cmd_ready), 32'd0);
        @(posedge Clock);
        #1;
        drain("simul");

        rr_mode = 2;
        send_rand(1'b0);
        for (int i = 0; i < 150; i++) begin
            idle(int'($urandom % 3));
            send_rand(1'($urandom));
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/accum_cmd_driver.md
Name: accum_cmd_driver

Overview:
- Command-side initiator for the 16-bit add/subtract accumulator unit. The unit has ports A, B, Sel, AddSub, Z and Overflow, and a fixed 2-cycle input-to-output latency.
- Buffers operation commands from a valid/ready producer, issues at most one per cycle onto the unit's operand ports, and captures the unit's Z/Overflow after the pipeline latency.
- Returns each result to a consumer through a buffered valid/ready result stream.
- Sits between a control/stimulus source and the accumulator datapath.

Parameters:
- n, 16, operand/result width
- LAT, 2, cycles from operand presentation to the matching Z/Overflow
- CDEPTH, 4, command FIFO depth (power of 2)
- RDEPTH, 4, result FIFO depth (power of 2, >= LAT)

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_a  in  n  operand A
- cmd_b  in  n  operand B
- cmd_sel  in  1  0: Z=A±B, 1: Z=Z±B (accumulate)
- cmd_addsub  in  1  0 add, 1 subtract
- A  out  n  to unit
- B  out  n  to unit
- Sel  out  1  to unit
- AddSub  out  1  to unit
- Z  in  n  from unit
- Overflow  in  1  from unit
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_z  out  n  result value
- res_ovf  out  1  result overflow flag
- busy  out  1  any command buffered or in flight, or any result unread

Behaviour:
- One clock; reset is synchronous and active-low: all state is cleared on a rising Clock edge with Reset=0.
- Reset values: cmd_ready=0 while Reset=0, then 1. A=0, B=0, Sel=1, AddSub=0, res_valid=0, res_z=0, res_ovf=0, busy=0. Both FIFOs are empty, the in-flight pipe is cleared and credits=RDEPTH.
- Command accept: on cmd_valid & cmd_ready, the command is written to the command FIFO. cmd_ready = !full, and it is registered-free (combinational from the count).
- Issue condition: the command FIFO is not empty and credits>0.
  - On issue, the head is popped and its fields are registered onto A/B/Sel/AddSub the following cycle.
  - A tag bit 1 is shifted into the LAT-stage valid pipe and credits decrements.
- Idle: when no issue occurs, drive Sel=1, B=0, AddSub=0, A=0 (the accumulator holds Z+0) and shift tag 0 into the pipe.
- Capture: when the tag at pipe stage LAT is 1, write {Z, Overflow} into the result FIFO. Credits guarantee the result FIFO never overflows.
- Result out: res_valid = result FIFO not empty, with res_z/res_ovf showing the head. On res_valid & res_ready, pop the head and increment credits.
- Simultaneous events:
  - A FIFO push and pop in the same cycle are both allowed and the count is unchanged.
  - An issue and a result pop in the same cycle leave credits unchanged.
  - An accept into a full FIFO is impossible because cmd_ready=0.
- Back-to-back: sustained throughput is one command per cycle while res_ready=1. Command-to-res_valid latency through an empty FIFO is 1 (FIFO) + 1 (issue register) + LAT cycles.
- Ordering: results are returned strictly in command order.
- FIFO pointers are log2(depth)+1 bits and wrap naturally. Full is "MSBs differ, rest equal".
- Reset mid-operation: buffered commands, in-flight tags and unread results are discarded, with no spurious res_valid after reset. The accumulator's own state is not reset by this block.
- busy = cmd FIFO not empty | pipe has any tag | result FIFO not empty.

Decomposition:
- Shared package: a command-field index constant set, and a function computing log2 for pointer widths.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty). It is instantiated twice: commands at width 2n+2, results at width n+1.
- The pipe, issue logic and credit counter stay in the top level.

Test Plan:
- Reset held 3 cycles then released -> cmd_ready rises to 1; A=B=0, Sel=1, res_valid=0, busy=0 throughout reset.
- Single command {A=54, B=1850, sel=0, addsub=0} with res_ready=1 -> exactly one res_valid, carrying res_z=1904, res_ovf=0.
- Burst of 4 back-to-back commands {750,120,0,1}, {0,7000,1,0}, {0,30000,1,0}, {0,5,1,0} -> results in order 630/0, 7630/0, 37630/1, 37635/0, at one per cycle.
- res_ready=0 while issuing 8 commands -> exactly RDEPTH issue while the rest wait. cmd_ready falls after 4 additional accepts. On release, all 8 results appear in order and none are lost.
- Reset asserted with 2 commands in flight and 1 result buffered -> after release, no res_valid until a new command is issued, and busy=0.
- Simultaneous cmd accept with the FIFO at depth 3, plus an issue in the same cycle -> count stays 3 and cmd_ready stays 1.
